id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 174 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush and hold control.
// Optional hazard-bubble counter enabled by defining ID_EX_STALL_CNT_EN.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegDst_i,
  input  logic        ALUSrc_i,
  input  logic        MemtoReg_i,
  input  logic        RegWrite_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic        Branch_i,
  input  logic [1:0]  ALUOp_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] rd1_i,
  input  logic [31:0] rd2_i,
  input  logic [31:0] imm_i,
  input  logic [5:0]  funct_i,
  input  logic        flush_i,
  input  logic        hold_i,
  output logic        RegDst_o,
  output logic        ALUSrc_o,
  output logic        MemtoReg_o,
  output logic        RegWrite_o,
  output logic        MemRead_o,
  output logic        MemWrite_o,
  output logic        Branch_o,
  output logic [1:0]  ALUOp_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  rd_o,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o,
  output logic [31:0] imm_o,
  output logic [5:0]  funct_o,
  output logic        pc_write,
  output logic        ifid_write,
  output logic [15:0] stall_cnt
);

  typedef struct packed {
    logic        reg_dst;
    logic        alu_src;
    logic        mem_to_reg;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic [1:0]  alu_op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [5:0]  funct;
  } idex_t;

  localparam idex_t BUBBLE = '0;

  idex_t in_s;
  idex_t idex_d;
  idex_t idex_q;
  logic  load_use_s;

  assign in_s = '{reg_dst:    RegDst_i,
                  alu_src:    ALUSrc_i,
                  mem_to_reg: MemtoReg_i,
                  reg_write:  RegWrite_i,
                  mem_read:   MemRead_i,
                  mem_write:  MemWrite_i,
                  branch:     Branch_i,
                  alu_op:     ALUOp_i,
                  rs:         rs_i,
                  rt:         rt_i,
                  rd:         rd_i,
                  rd1:        rd1_i,
                  rd2:        rd2_i,
                  imm:        imm_i,
                  funct:      funct_i};

  // A load in EX whose destination feeds the instruction now in ID must wait one cycle.
  assign load_use_s = idex_q.mem_read && (idex_q.rt != 5'd0) &&
                      ((idex_q.rt == rs_i) || (idex_q.rt == rt_i));

  // Next-state selection: hold > flush > load-use bubble > normal load.
  always_comb begin
    idex_d = in_s;
    if (hold_i) begin
      idex_d = idex_q;
    end else if (flush_i) begin
      idex_d = BUBBLE;
    end else if (load_use_s) begin
      idex_d = BUBBLE;
    end else begin
      idex_d = in_s;
    end
  end

  // Upstream write enables.
  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    if (hold_i) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (flush_i) begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
    end else if (load_use_s) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
    end
  end

  // Pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_q <= BUBBLE;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign RegDst_o   = idex_q.reg_dst;
  assign ALUSrc_o   = idex_q.alu_src;
  assign MemtoReg_o = idex_q.mem_to_reg;
  assign RegWrite_o = idex_q.reg_write;
  assign MemRead_o  = idex_q.mem_read;
  assign MemWrite_o = idex_q.mem_write;
  assign Branch_o   = idex_q.branch;
  assign ALUOp_o    = idex_q.alu_op;
  assign rs_o       = idex_q.rs;
  assign rt_o       = idex_q.rt;
  assign rd_o       = idex_q.rd;
  assign rd1_o      = idex_q.rd1;
  assign rd2_o      = idex_q.rd2;
  assign imm_o      = idex_q.imm;
  assign funct_o    = idex_q.funct;

`ifdef ID_EX_STALL_CNT_EN
  logic [15:0] stall_cnt_d;
  logic [15:0] stall_cnt_q;

  // Only load-use bubbles are counted; the count saturates.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!hold_i && !flush_i && load_use_s && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;

  logic        clk;
  logic        rst;
  logic        RegDst_i, ALUSrc_i, MemtoReg_i, RegWrite_i, MemRead_i, MemWrite_i, Branch_i;
  logic [1:0]  ALUOp_i;
  logic [4:0]  rs_i, rt_i, rd_i;
  logic [31:0] rd1_i, rd2_i, imm_i;
  logic [5:0]  funct_i;
  logic        flush_i, hold_i;
  logic        RegDst_o, ALUSrc_o, MemtoReg_o, RegWrite_o, MemRead_o, MemWrite_o, Branch_o;
  logic [1:0]  ALUOp_o;
  logic [4:0]  rs_o, rt_o, rd_o;
  logic [31:0] rd1_o, rd2_o, imm_o;
  logic [5:0]  funct_o;
  logic        pc_write, ifid_write;
  logic [15:0] stall_cnt;

  int total;
  int bad;
  logic [15:0] exp_cnt;

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .RegDst_i(RegDst_i), .ALUSrc_i(ALUSrc_i), .MemtoReg_i(MemtoReg_i), .RegWrite_i(RegWrite_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .Branch_i(Branch_i), .ALUOp_i(ALUOp_i),
    .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .rd1_i(rd1_i), .rd2_i(rd2_i), .imm_i(imm_i),
    .funct_i(funct_i), .flush_i(flush_i), .hold_i(hold_i),
    .RegDst_o(RegDst_o), .ALUSrc_o(ALUSrc_o), .MemtoReg_o(MemtoReg_o), .RegWrite_o(RegWrite_o),
    .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .Branch_o(Branch_o), .ALUOp_o(ALUOp_o),
    .rs_o(rs_o), .rt_o(rt_o), .rd_o(rd_o), .rd1_o(rd1_o), .rd2_o(rd2_o), .imm_o(imm_o),
    .funct_o(funct_o), .pc_write(pc_write), .ifid_write(ifid_write), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    {RegDst_i, ALUSrc_i, MemtoReg_i, RegWrite_i, MemRead_i, MemWrite_i, Branch_i} = 7'd0;
    ALUOp_i = 2'd0; rs_i = 5'd0; rt_i = 5'd0; rd_i = 5'd0;
    rd1_i = 32'd0; rd2_i = 32'd0; imm_i = 32'd0; funct_i = 6'd0;
  endtask

  task automatic lw(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] imm);
    idle();
    ALUSrc_i = 1'b1; MemtoReg_i = 1'b1; RegWrite_i = 1'b1; MemRead_i = 1'b1;
    rs_i = rs; rt_i = rt; imm_i = imm;
  endtask

  task automatic rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b, input logic [5:0] fn);
    idle();
    RegDst_i = 1'b1; RegWrite_i = 1'b1; ALUOp_i = 2'b10;
    rs_i = rs; rt_i = rt; rd_i = rd; rd1_i = a; rd2_i = b; funct_i = fn;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bubble(input string tag);
    check({tag, ".ctl"}, {25'd0, RegDst_o, ALUSrc_o, MemtoReg_o, RegWrite_o, MemRead_o,
                          MemWrite_o, Branch_o}, 32'd0);
    check({tag, ".aluop"}, {30'd0, ALUOp_o}, 32'd0);
    check({tag, ".spec"}, {17'd0, rs_o, rt_o, rd_o}, 32'd0);
    check({tag, ".data"}, rd1_o | rd2_o | imm_o | {26'd0, funct_o}, 32'd0);
  endtask

  initial begin
    total = 0;
    bad = 0;
`ifdef ID_EX_STALL_CNT_EN
    exp_cnt = 16'd1;
`else
    exp_cnt = 16'd0;
`endif
    rst = 1'b1; flush_i = 1'b0; hold_i = 1'b0;
    rtype(5'd3, 5'd4, 5'd9, 32'hDEAD_BEEF, 32'h0BAD_F00D, 6'h22);
    MemRead_i = 1'b1; Branch_i = 1'b1; imm_i = 32'h0000_FFFF;
    #3;
    check_bubble("reset");
    check("reset.pc_write", {31'd0, pc_write}, 32'd1);
    check("reset.ifid_write", {31'd0, ifid_write}, 32'd1);
    check("reset.stall_cnt", {16'd0, stall_cnt}, 32'd0);
    tick();
    check_bubble("reset.clocked");
    hold_i = 1'b1; #1;
    check("reset.hold_pc", {31'd0, pc_write}, 32'd0);
    hold_i = 1'b0;

    // Pass-through of an R-format instruction.
    @(negedge clk); rst = 1'b0;
    rtype(5'd1, 5'd2, 5'd3, 32'h1234_5678, 32'h8765_4321, 6'h20);
    #1;
    check("pass.pc_write", {31'd0, pc_write}, 32'd1);
    tick();
    check("pass.RegDst", {31'd0, RegDst_o}, 32'd1);
    check("pass.RegWrite", {31'd0, RegWrite_o}, 32'd1);
    check("pass.ALUOp", {30'd0, ALUOp_o}, 32'd2);
    check("pass.rd1", rd1_o, 32'h1234_5678);
    check("pass.rd2", rd2_o, 32'h8765_4321);
    check("pass.spec", {17'd0, rs_o, rt_o, rd_o}, {17'd0, 5'd1, 5'd2, 5'd3});
    check("pass.funct", {26'd0, funct_o}, 32'h20);

    // Load-use: lw rt=5 followed by a consumer of r5.
    @(negedge clk); lw(5'd1, 5'd5, 32'h0000_0004);
    tick();
    check("lw.MemRead", {31'd0, MemRead_o}, 32'd1);
    check("lw.imm", imm_o, 32'h4);
    @(negedge clk); rtype(5'd5, 5'd6, 5'd7, 32'h0000_0011, 32'h0000_0022, 6'h20);
    #1;
    check("lu.pc_write", {31'd0, pc_write}, 32'd0);
    check("lu.ifid_write", {31'd0, ifid_write}, 32'd0);
    tick();
    check_bubble("lu.bubble");
    check("lu.pc_after", {31'd0, pc_write}, 32'd1);
    tick();
    check("lu.adv.rd", {27'd0, rd_o}, 32'd7);
    check("lu.adv.rd1", rd1_o, 32'h11);
    check("lu.adv.RegDst", {31'd0, RegDst_o}, 32'd1);
    check("lu.stall_cnt", {16'd0, stall_cnt}, {16'd0, exp_cnt});

    // Load to r0 never stalls.
    @(negedge clk); lw(5'd2, 5'd0, 32'h8);
    tick();
    @(negedge clk); rtype(5'd0, 5'd0, 5'd8, 32'h1, 32'h2, 6'h20);
    #1;
    check("r0.pc_write", {31'd0, pc_write}, 32'd1);
    check("r0.ifid_write", {31'd0, ifid_write}, 32'd1);

    // Flush wins over load-use and is not counted.
    @(negedge clk); lw(5'd1, 5'd5, 32'h10);
    tick();
    @(negedge clk); rtype(5'd6, 5'd5, 5'd7, 32'h3, 32'h4, 6'h20); flush_i = 1'b1;
    #1;
    check("flush.pc_write", {31'd0, pc_write}, 32'd1);
    check("flush.ifid_write", {31'd0, ifid_write}, 32'd1);
    tick();
    check_bubble("flush.bubble");
    check("flush.stall_cnt", {16'd0, stall_cnt}, {16'd0, exp_cnt});
    flush_i = 1'b0;

    // Hold freezes the register for three cycles while inputs change.
    @(negedge clk); rtype(5'd10, 5'd11, 5'd12, 32'hAAAA_5555, 32'h5555_AAAA, 6'h24);
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      lw(5'(i + 1), 5'(i + 13), 32'(i + 100));
      hold_i = 1'b1;
      #1;
      check("hold.pc_write", {31'd0, pc_write}, 32'd0);
      check("hold.ifid_write", {31'd0, ifid_write}, 32'd0);
      tick();
      check("hold.rd1", rd1_o, 32'hAAAA_5555);
      check("hold.spec", {17'd0, rs_o, rt_o, rd_o}, {17'd0, 5'd10, 5'd11, 5'd12});
      check("hold.MemRead", {31'd0, MemRead_o}, 32'd0);
      check("hold.stall_cnt", {16'd0, stall_cnt}, {16'd0, exp_cnt});
    end
    @(negedge clk); hold_i = 1'b0;
    tick();
    check("unhold.imm", imm_o, 32'd102);
    check("unhold.rt", {27'd0, rt_o}, 32'd15);

    // Reset during a pending stall discards it.
    @(negedge clk); rtype(5'd15, 5'd1, 5'd20, 32'h77, 32'h88, 6'h25);
    #1;
    check("rststall.pc_write", {31'd0, pc_write}, 32'd0);
    rst = 1'b1; #1;
    check("rststall.MemRead", {31'd0, MemRead_o}, 32'd0);
    check("rststall.pc_rst", {31'd0, pc_write}, 32'd1);
    check("rststall.cnt", {16'd0, stall_cnt}, 32'd0);
    @(negedge clk); rst = 1'b0;
    tick();
    check("rststall.rd", {27'd0, rd_o}, 32'd20);
    check("rststall.rd1", rd1_o, 32'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
